// File: rtl/pxl_frame_streamer.sv
// pxl_frame_streamer: loads one IMG_W x IMG_H frame and replays it as a gap-free raster stream followed by FLUSH_LEN zero pixels.
// Optional macro PXL_STREAM_REPLAY_EN adds a replay input that re-streams the stored frame without a reload.
module pxl_frame_streamer #(
    parameter int PP        = 8,
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int FLUSH_LEN = 64
) (
    input  logic             clk,
    input  logic             reset,
`ifdef PXL_STREAM_REPLAY_EN
    input  logic             replay,
`endif
    input  logic signed [PP:0] in_pxl,
    input  logic             in_valid,
    output logic             in_ready,
    output logic signed [PP:0] pxl_out,
    output logic             out_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);
    localparam int N  = IMG_W * IMG_H;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [FW-1:0] FLAST = FW'(FLUSH_LEN - 1);
    localparam logic [1:0] LOAD = 2'd0, STREAM = 2'd1, FLUSH = 2'd2;

    logic [1:0]        state;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [FW-1:0]     flush_cnt;
    logic              frame_loaded, rd_done, rd_en, wr_en, replay_go;
    logic              s1_valid, s1_sof, s1_eof;
    logic signed [PP:0] s1_data;
    logic signed [PP:0] mem [0:N-1];

`ifdef PXL_STREAM_REPLAY_EN
    assign replay_go = replay && state == LOAD && wr_addr == '0 && frame_loaded;
`else
    assign replay_go = 1'b0;
`endif
    assign in_ready = state == LOAD && !replay_go;
    assign wr_en    = in_valid && in_ready;
    assign rd_en    = state == STREAM && !rd_done;
    assign busy     = state == STREAM || state == FLUSH;

    // Frame buffer: write on handshake, registered read feeding the output stage.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= in_pxl;
        s1_data <= mem[rd_addr];
    end

    // Control FSM, address counters and the two-stage read/output pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= LOAD;
            wr_addr      <= '0;
            rd_addr      <= '0;
            flush_cnt    <= '0;
            frame_loaded <= 1'b0;
            rd_done      <= 1'b0;
            s1_valid     <= 1'b0;
            s1_sof       <= 1'b0;
            s1_eof       <= 1'b0;
            pxl_out      <= '0;
            out_valid    <= 1'b0;
            sof          <= 1'b0;
            eof          <= 1'b0;
        end else begin
            if (wr_en) wr_addr <= (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
            if (wr_en && wr_addr == LAST) frame_loaded <= 1'b1;
            if (rd_en) rd_addr <= (rd_addr == LAST) ? '0 : rd_addr + 1'b1;
            rd_done <= state == STREAM && (rd_done || rd_addr == LAST);
            if (state == LOAD && (replay_go || (wr_en && wr_addr == LAST))) begin
                state <= STREAM;
            end else if (state == STREAM && eof) begin
                state     <= FLUSH;
                flush_cnt <= '0;
            end else if (state == FLUSH) begin
                flush_cnt <= (flush_cnt == FLAST) ? '0 : flush_cnt + 1'b1;
                if (flush_cnt == FLAST) state <= LOAD;
            end
            s1_valid  <= rd_en;
            s1_sof    <= rd_en && rd_addr == '0;
            s1_eof    <= rd_en && rd_addr == LAST;
            out_valid <= s1_valid;
            sof       <= s1_sof;
            eof       <= s1_eof;
            pxl_out   <= s1_valid ? s1_data : '0;
        end
    end
endmodule

// File: tb/tb_pxl_frame_streamer.sv
// tb_pxl_frame_streamer: 32x32 instance checked by a timeline reference model, 4x2 instance checked by a vector table.
module tb_pxl_frame_streamer;
    localparam int PP = 8, W = 32, H = 32, F = 64, N = W * H;
    localparam int SW = 4, SH = 2, SF = 1, SN = SW * SH;
    localparam int SP = 2 * SN + SF + 2;
`ifdef PXL_STREAM_REPLAY_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    logic signed [PP:0] in_pxl, pxl_out, s_in_pxl, s_pxl_out;
    logic in_valid, in_ready, out_valid, sof, eof, busy;
    logic s_in_valid, s_in_ready, s_out_valid, s_sof, s_eof, s_busy;
`ifdef PXL_STREAM_REPLAY_EN
    logic replay;
`endif
    int checks = 0, failures = 0;

    pxl_frame_streamer #(.PP(PP), .IMG_W(W), .IMG_H(H), .FLUSH_LEN(F)) dut (
        .clk(clk), .reset(reset),
`ifdef PXL_STREAM_REPLAY_EN
        .replay(replay),
`endif
        .in_pxl(in_pxl), .in_valid(in_valid), .in_ready(in_ready),
        .pxl_out(pxl_out), .out_valid(out_valid), .sof(sof), .eof(eof), .busy(busy)
    );

    pxl_frame_streamer #(.PP(PP), .IMG_W(SW), .IMG_H(SH), .FLUSH_LEN(SF)) sdut (
        .clk(clk), .reset(reset),
`ifdef PXL_STREAM_REPLAY_EN
        .replay(1'b0),
`endif
        .in_pxl(s_in_pxl), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .pxl_out(s_pxl_out), .out_valid(s_out_valid), .sof(s_sof), .eof(s_eof), .busy(s_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: k = clock edges since the frame-start edge (-1 while loading).
    logic signed [PP:0] fmem [N];
    int  k = -1, wcnt = 0;
    bit  loaded = 1'b0;

    task automatic cyc(input logic v, input logic signed [PP:0] d, input logic rp);
        logic rg, ov;
        logic signed [PP:0] q;
        rg = REP && rp && k < 0 && wcnt == 0 && loaded;
`ifdef PXL_STREAM_REPLAY_EN
        replay = rp;
`endif
        in_valid = v;
        in_pxl   = d;
        #1 chk("in_ready", in_ready, k < 0 && !rg);
        @(posedge clk);
        if (k < 0) begin
            if (rg) k = 0;
            else if (v) begin
                fmem[wcnt] = d;
                wcnt++;
                if (wcnt == N) begin
                    wcnt = 0;
                    loaded = 1'b1;
                    k = 0;
                end
            end
        end else begin
            k++;
            if (k == N + 2 + F) k = -1;
        end
        @(negedge clk);
        ov = k >= 2 && k <= N + 1;
        q  = ov ? fmem[k-2] : '0;
        chk("out_valid", out_valid, ov);
        chk("pxl_out", pxl_out, q);
        chk("sof", sof, k == 2);
        chk("eof", eof, k == N + 1);
        chk("busy", busy, k >= 0);
    endtask

    task automatic load_random();
        logic signed [PP:0] d;
        int n;
        for (n = 0; k < 0 && n < 20000; n++) begin
            d = (wcnt == 0) ? 9'h100 : (wcnt == 1) ? 9'h0FF : 9'($urandom);
            cyc($urandom_range(0, 2) != 0, d, REP && $urandom_range(0, 39) == 0);
        end
        if (k < 0) chk("load_timeout", 32'(n), 32'(-1));
    endtask

    task automatic drain();
        int n;
        for (n = 0; k >= 0 && n < N + F + 10; n++) cyc(1'b1, 9'($urandom), 1'b0);
        if (k >= 0) chk("drain_timeout", 32'(n), 32'(-1));
    endtask

    function automatic logic signed [PP:0] sdat(int f, int i);
        return 9'(f * 77 + i * 31 - 120);
    endfunction

    typedef struct {
        logic v;
        logic signed [PP:0] d;
        logic rdy, ov, sof, eof, busy;
        logic signed [PP:0] q;
    } vec_t;
    vec_t tv [2*SP];

    initial begin
        for (int j = 0; j < 2 * SP; j++) begin
            int f, off, kk;
            f  = j / SP;
            off = j % SP;
            kk = off - (SN - 1);
            tv[j].v    = 1'b1;
            tv[j].d    = (off < SN) ? sdat(f, off) : 9'(j * 7 + 3);
            tv[j].rdy  = off < SN - 1 || kk == SN + SF + 2;
            tv[j].busy = kk >= 0 && kk <= SN + SF + 1;
            tv[j].ov   = kk >= 2 && kk <= SN + 1;
            tv[j].q    = tv[j].ov ? sdat(f, kk - 2) : '0;
            tv[j].sof  = kk == 2;
            tv[j].eof  = kk == SN + 1;
        end
        in_valid = 1'b0; in_pxl = '0; s_in_valid = 1'b0; s_in_pxl = '0;
`ifdef PXL_STREAM_REPLAY_EN
        replay = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pxl_out", pxl_out, 0);
        chk("rst_sof", sof, 0);
        chk("rst_eof", eof, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("s_rst_in_ready", s_in_ready, 1);

        for (int j = 0; j < 2 * SP; j++) begin
            s_in_valid = tv[j].v;
            s_in_pxl   = tv[j].d;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("s_in_ready[%0d]", j), s_in_ready, tv[j].rdy);
            chk($sformatf("s_busy[%0d]", j), s_busy, tv[j].busy);
            chk($sformatf("s_out_valid[%0d]", j), s_out_valid, tv[j].ov);
            chk($sformatf("s_pxl_out[%0d]", j), s_pxl_out, tv[j].q);
            chk($sformatf("s_sof[%0d]", j), s_sof, tv[j].sof);
            chk($sformatf("s_eof[%0d]", j), s_eof, tv[j].eof);
        end
        s_in_valid = 1'b0;

        for (int i = 0; i < N; i++) cyc(1'b1, 9'(i), 1'b0);
        drain();
        load_random();
        drain();

        for (int n = 0; k < 0 && n < 5000; n++) cyc(1'b1, 9'($urandom), 1'b0);
        for (int n = 0; k < 502 && n < 1000; n++) cyc(1'b1, 9'($urandom), 1'b0);
        chk("pre_reset_k", 32'(k), 502);
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_pxl_out", pxl_out, 0);
        chk("mid_rst_busy", busy, 0);
        k = -1; wcnt = 0; loaded = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        load_random();
        drain();

`ifdef PXL_STREAM_REPLAY_EN
        for (int i = 0; i < 5; i++) cyc(1'b1, 9'($urandom), 1'b0);
        cyc(1'b1, 9'h033, 1'b1);
        for (int n = 0; k < 0 && n < N; n++) cyc(1'b1, 9'($urandom), 1'b0);
        drain();
        cyc(1'b1, 9'h055, 1'b1);
        drain();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pxl_frame_streamer.md
Name: pxl_frame_streamer

Overview:
- Source-side counterpart of the layer_1 convolution/max-pool channels.
- Accepts one IMG_W x IMG_H frame over a valid/ready write interface and stores it in an internal frame buffer.
- Replays the stored frame as a gap-free raster stream, one pixel per clock, to drive the free-running pxl_in of a layer.
- Follows each frame with FLUSH_LEN zero pixels so the conv/pool pipeline drains.

Parameters:
- PP, 8: pixel MSB index; pixels are signed [PP:0].
- IMG_W, 32: pixels per row.
- IMG_H, 32: rows per frame; N = IMG_W*IMG_H.
- FLUSH_LEN, 64: zero pixels emitted after each frame; must be >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_pxl  in  PP+1  signed pixel from upstream loader.
- in_valid  in  1  in_pxl valid.
- in_ready  out  1  streamer can accept a pixel; transfer occurs when in_valid && in_ready.
- pxl_out  out  PP+1  signed pixel to layer pxl_in; 0 when not streaming.
- out_valid  out  1  pxl_out carries a frame pixel (high for exactly N consecutive cycles per frame).
- sof  out  1  one-cycle pulse with pixel 0.
- eof  out  1  one-cycle pulse with pixel N-1.
- busy  out  1  high in STREAM or FLUSH.

Behaviour:
- States: LOAD, STREAM, FLUSH. The reset state is LOAD.
- Reset (reset=0, async): state=LOAD, wr_addr=0, rd_addr=0, flush_cnt=0, frame_loaded=0; in_ready=1 after release; pxl_out=0, out_valid=0, sof=0, eof=0, busy=0. Buffer contents are not cleared. Reset mid-STREAM/FLUSH aborts immediately; the next frame must be fully reloaded.
- LOAD:
  - in_ready = 1.
  - Each handshake writes mem[wr_addr] and increments wr_addr.
  - A handshake with wr_addr==N-1 sets frame_loaded=1, wraps wr_addr to 0, and enters STREAM on the same edge. in_ready is 0 from the following cycle.
  - in_valid gaps are allowed; no timeout.
- STREAM:
  - Synchronous buffer read, 1-cycle latency.
  - rd_addr runs 0..N-1, one step per clock.
  - pxl_out/out_valid are registered. Pixel 0 appears 2 clocks after the last-input handshake edge; that edge is E0, pixel 0 appears after E2.
  - The stream is N consecutive out_valid cycles. sof is coincident with pixel 0; eof is coincident with pixel N-1. If N==1, both pulses are high together.
  - Raster order: pixel index = row*IMG_W + col, identical to load order.
  - There is no downstream backpressure; the stream never stalls.
- FLUSH:
  - Entered on the cycle after pixel N-1.
  - FLUSH_LEN cycles with pxl_out=0 and out_valid=0.
  - Then returns to LOAD; in_ready rises on the cycle after the last flush cycle.
- in_valid while in_ready=0 is ignored. Upstream must hold data.
- busy = (state==STREAM || state==FLUSH), including the 1-cycle read-latency bubble.
- Counter widths: ceil(log2(N)) for addresses, ceil(log2(FLUSH_LEN+1)) for flush_cnt. All counters wrap to 0 explicitly, never by overflow.

Optional Feature:
- Macro: PXL_STREAM_REPLAY_EN.
- Defined: adds input port replay (1 bit).
  - In LOAD with wr_addr==0 and frame_loaded==1, replay=1 enters STREAM next edge and re-emits the stored frame. This serves sequential evaluation of multiple layer channels without a reload.
  - If replay and in_valid arrive in the same cycle, replay wins: in_ready is forced 0 that cycle (combinational from replay) and no write occurs.
  - replay is ignored when frame_loaded==0, when wr_addr!=0, or outside LOAD.
- Undefined: no replay port; every stream requires a full reload.

Test Plan:
- Load ramp 0..1023 with continuous in_valid, IMG 32x32 -> in_ready drops after pixel 1023. Pixel 0 is output 2 clocks after the last handshake with sof=1. Output is 1024 consecutive values 0..1023; eof coincides with value 1023. Then 64 cycles of pxl_out=0, then in_ready=1.
- Load with random in_valid gaps, values -256..255 -> the output stream is bit-identical in order and contiguous with no gaps; signed values are preserved (e.g. -256 is emitted as 9'h100).
- Hold in_valid=1 during STREAM/FLUSH with changing data -> no buffer write; the next load's data is unaffected.
- Assert reset low at stream pixel 500 -> outputs go to 0 immediately and in_ready=1 after release. A fresh 1024-pixel load is required before any output (sof does not occur early).
- With PXL_STREAM_REPLAY_EN: after one frame and flush, pulse replay -> the identical 1024-pixel stream is repeated. replay before any load or at wr_addr=5 -> no effect. Replay with simultaneous in_valid -> in_ready=0 that cycle and that in_pxl is not written.
- Set IMG_W=4, IMG_H=2, FLUSH_LEN=1 -> 8 output pixels then 1 flush cycle; boundary wraps are correct and back-to-back frames work.
